// File: rtl/conv_frame_scheduler.sv
// Frame scheduler feeding a line-buffered convolution engine: meters upstream pixels
// against line-buffer credit. Optional STALL_CNT_EN macro adds a saturating stall_cycles counter.
module conv_frame_scheduler #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int NUM_LB = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        row_intr,
  output logic        busy,
  output logic        frame_done,
  output logic [9:0]  rows_out,
  output logic        ovf_err,
`ifdef STALL_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic [1:0]  state_dbg,
  output logic [11:0] credit_dbg
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [11:0] CREDIT_MAX = 12'(NUM_LB * IMG_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     credit_q, credit_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      rows_q, rows_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            accept;
  logic            active;
  logic            last_pix;
  logic [12:0]     credit_sum;

  // Handshake: a pixel transfers on any posedge where s_valid && s_ready; s_ready
  // never depends on s_valid, and s_valid may be held high while s_ready is low.
  assign s_ready  = (state_q == STREAM) && (credit_q != 12'd0);
  assign accept   = s_valid && s_ready;
  assign active   = (state_q == STREAM) || (state_q == DRAIN);
  assign last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    ovf_d        = ovf_q;
    rows_d       = rows_q;
    col_d        = col_q;
    row_d        = row_q;
    pix_data_d   = accept ? s_data : pix_data_q;
    pix_valid_d  = accept;
    credit_sum   = 13'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          credit_d = CREDIT_MAX;
          ovf_d    = 1'b0;
          rows_d   = 10'd0;
          col_d    = '0;
          row_d    = '0;
        end
      end
      STREAM: begin
        if (accept && last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        if (rows_q >= 10'(IMG_H - 2)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A row release and a pixel accept in the same cycle net out to +IMG_W-1.
    if (active) begin
      credit_sum = {1'b0, credit_q}
                 + (row_intr ? 13'(IMG_W) : 13'd0)
                 - (accept ? 13'd1 : 13'd0);
      if (row_intr && (credit_sum > {1'b0, CREDIT_MAX})) begin
        credit_d = CREDIT_MAX;
        ovf_d    = 1'b1;
      end else begin
        credit_d = credit_sum[11:0];
      end
      if (row_intr) rows_d = rows_q + 10'd1;
    end

    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      credit_q     <= CREDIT_MAX;
      ovf_q        <= 1'b0;
      rows_q       <= 10'd0;
      col_q        <= '0;
      row_q        <= '0;
      pix_data_q   <= 8'd0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      ovf_q        <= ovf_d;
      rows_q       <= rows_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = 16'd0;
    end else if ((state_q == STREAM) && s_valid && !s_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= 16'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rows_out   = rows_q;
  assign ovf_err    = ovf_q;
  assign state_dbg  = state_q;
  assign credit_dbg = credit_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler at IMG_W=8, IMG_H=6, NUM_LB=4 (credit max 32).
module tb_conv_frame_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        row_intr;
  logic        busy;
  logic        frame_done;
  logic [9:0]  rows_out;
  logic        ovf_err;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  logic [1:0]  state_dbg;
  logic [11:0] credit_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int pix_n       = 0;
  int first_low   = -1;

  conv_frame_scheduler #(.IMG_W(8), .IMG_H(6), .NUM_LB(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .row_intr   (row_intr),
    .busy       (busy),
    .frame_done (frame_done),
    .rows_out   (rows_out),
    .ovf_err    (ovf_err),
`ifdef STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .state_dbg  (state_dbg),
    .credit_dbg (credit_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one clock with the given valid/row_intr; tracks accepted pixels and checks the output register
  task automatic cyc(input logic v, input logic ri);
    logic acc;
    s_valid  = v;
    row_intr = ri;
    s_data   = pix_n[7:0];
    acc      = v && s_ready;
    step();
    s_valid  = 1'b0;
    row_intr = 1'b0;
    chk("pix_valid", 32'(pix_valid), 32'(acc));
    if (acc) begin
      chk("pix_data", 32'(pix_data), 32'(pix_n[7:0]));
      pix_n++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_state", 32'(state_dbg), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_credit", 32'(credit_dbg), 32);
    chk("start_rows", 32'(rows_out), 0);
    chk("start_ovf", 32'(ovf_err), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_rows_out"}, 32'(rows_out), 0);
    chk({tag, "_ovf_err"}, 32'(ovf_err), 0);
    chk({tag, "_credit"}, 32'(credit_dbg), 32);
`ifdef STALL_CNT_EN
    chk({tag, "_stall"}, 32'(stall_cycles), 0);
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; row_intr = 1'b0;
    step();
    step();
    chk_reset_values("por");
    reset = 1'b0;
    step();

    // credit exhaustion with s_valid held high, no row_intr
    do_start();
    for (int i = 0; i < 40; i++) begin
      if (!s_ready && first_low < 0) first_low = i;
      cyc(1'b1, 1'b0);
    end
    chk("t1_accepted", 32'(pix_n), 32);
    chk("t1_first_low", 32'(first_low), 32);
    chk("t1_s_ready", 32'(s_ready), 0);
    chk("t1_credit", 32'(credit_dbg), 0);
    chk("t1_pix_data_hold", 32'(pix_data), 31);
`ifdef STALL_CNT_EN
    chk("t1_stall", 32'(stall_cycles), 8);
`endif

    // single row release from a stall
    cyc(1'b0, 1'b1);
    chk("t2_credit", 32'(credit_dbg), 8);
    chk("t2_rows", 32'(rows_out), 1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
    chk("t2_accepted", 32'(pix_n), 40);
    chk("t2_s_ready", 32'(s_ready), 0);

    // credit 10 with simultaneous accept and row_intr, then finish the frame
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("t3_credit16", 32'(credit_dbg), 16);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    chk("t3_credit10", 32'(credit_dbg), 10);
    cyc(1'b1, 1'b1);
    chk("t3_credit17", 32'(credit_dbg), 17);
    chk("t3_rows4", 32'(rows_out), 4);
    chk("t3_state_stream", 32'(state_dbg), 1);
    cyc(1'b1, 1'b0);
    chk("t3_accepted", 32'(pix_n), 48);
    chk("t3_state_drain", 32'(state_dbg), 2);
    chk("t3_drain_busy", 32'(busy), 1);
    chk("t3_drain_done", 32'(frame_done), 0);
    cyc(1'b0, 1'b0);
    chk("t3_state_done", 32'(state_dbg), 3);
    chk("t3_frame_done", 32'(frame_done), 1);
    chk("t3_done_busy", 32'(busy), 1);
    cyc(1'b0, 1'b0);
    chk("t3_state_idle", 32'(state_dbg), 0);
    chk("t3_frame_done_low", 32'(frame_done), 0);
    chk("t3_busy_low", 32'(busy), 0);
    cyc(1'b0, 1'b1);
    chk("t3_idle_rows_hold", 32'(rows_out), 4);

    // overflow at full credit, start ignored mid-frame, ovf cleared by next start
    pix_n = 0;
    do_start();
    cyc(1'b0, 1'b1);
    chk("t4_ovf", 32'(ovf_err), 1);
    chk("t4_credit_clamp", 32'(credit_dbg), 32);
    chk("t4_rows", 32'(rows_out), 1);
    start = 1'b1;
    cyc(1'b0, 1'b0);
    start = 1'b0;
    chk("t4_start_ignored", 32'(state_dbg), 1);
    chk("t4_ovf_sticky", 32'(ovf_err), 1);
    for (int k = 0; k < 48; k++) cyc(1'b1, (k == 7) || (k == 15) || (k == 23));
    chk("t4_accepted", 32'(pix_n), 48);
    chk("t4_state_drain", 32'(state_dbg), 2);
    chk("t4_credit_end", 32'(credit_dbg), 8);
    cyc(1'b0, 1'b0);
    chk("t4_frame_done", 32'(frame_done), 1);
    cyc(1'b0, 1'b0);
    chk("t4_idle", 32'(state_dbg), 0);
    chk("t4_ovf_in_idle", 32'(ovf_err), 1);
    pix_n = 0;
    do_start();

    // reset mid-frame after 20 pixels
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    chk("t5_accepted", 32'(pix_n), 20);
    chk("t5_credit", 32'(credit_dbg), 12);
    reset = 1'b1;
    step();
    chk_reset_values("midrst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_frame_done", 32'(frame_done), 0);
      chk("t5_stay_idle", 32'(state_dbg), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
